mem_arbiter: RTL

Shares one single-port synchronous memory between the core's instruction-fetch port and its load/store port, so one RAM serves as both instruction and data memory. It sits between the core and a single memory instance and multiplexes address, write data and controls to the memory. It routes the one-cycle-late read data and completion strobe back to the port that owns the transaction. One transaction is issued per cycle, so back-to-back grants sustain full throughput.

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous memory between the instruction-fetch (IF)
// port and the load/store (LS) port of a core. At most one request is granted
// per cycle; the granted port's address, data and controls are steered to the
// memory, and the one-cycle-late read data / completion strobe is routed back
// to whichever port owned the transaction.
//
// Arbitration: a lone requester is granted; on a tie LS wins. With the
// optional starvation guard compiled in (define MEM_ARB_STARVE_GUARD_EN), a
// fetch that has been denied STARVE_LIMIT consecutive cycles wins the next tie.
//
// Parameters:
//   WORD_SIZE    data width in bits (multiple of 8)
//   ADDR_WIDTH   address width in bits
//   STARVE_LIMIT denied fetch cycles before fetch is forced through (>= 1)
//
// Ports:
//   clk_i, rst_ni                      clock (rising edge), async active-low reset
//   if_req_i, if_addr_i                fetch request and address
//   if_gnt_o, if_rvalid_o, if_rdata_o  fetch grant, response strobe, read data
//   ls_req_i, ls_we_i, ls_be_i,
//   ls_addr_i, ls_wdata_i              load/store request, direction, byte
//                                      enables, address, store data
//   ls_gnt_o, ls_rvalid_o, ls_rdata_o  load/store grant, response strobe, data
//   mem_req_o, mem_we_o, mem_be_o,
//   mem_addr_o, mem_wdata_o            memory access controls and write data
//   mem_rdata_i                        memory read data (cycle after mem_req_o)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WORD_SIZE    = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    output logic [WORD_SIZE-1:0]    if_rdata_o,

    input  logic                    ls_req_i,
    input  logic                    ls_we_i,
    input  logic [WORD_SIZE/8-1:0]  ls_be_i,
    input  logic [ADDR_WIDTH-1:0]   ls_addr_i,
    input  logic [WORD_SIZE-1:0]    ls_wdata_i,
    output logic                    ls_gnt_o,
    output logic                    ls_rvalid_o,
    output logic [WORD_SIZE-1:0]    ls_rdata_o,

    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [WORD_SIZE/8-1:0]  mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [WORD_SIZE-1:0]    mem_wdata_o,
    input  logic [WORD_SIZE-1:0]    mem_rdata_i
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    owner_e owner_q, owner_d;
    logic   force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign force_if = (starve_q == CNT_W'(STARVE_LIMIT));

    // Counts consecutive cycles in which fetch asked but was refused.
    // Saturates at the limit; any fetch grant or idle fetch cycle restarts it.
    always_comb begin
        starve_d = starve_q;
        if (!if_req_i || if_gnt_o) begin
            starve_d = '0;
        end else if (starve_q != CNT_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Without the guard LS always wins ties; STARVE_LIMIT has no effect.
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign force_if            = 1'b0;
`endif

    // Grants are combinational; rst_ni gates them so nothing reaches the
    // memory while reset is held.
    assign if_gnt_o  = rst_ni && if_req_i && (!ls_req_i || force_if);
    assign ls_gnt_o  = rst_ni && ls_req_i && !(if_req_i && force_if);
    assign mem_req_o = if_gnt_o | ls_gnt_o;

    // Memory-side steering. Fetch is always a full-word read. With no grant
    // the address/data simply follow the LS port (don't-care to the memory).
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = ls_addr_i;
        mem_wdata_o = ls_wdata_i;
        if (if_gnt_o) begin
            mem_be_o   = '1;
            mem_addr_o = if_addr_i;
        end else if (ls_gnt_o) begin
            mem_we_o = ls_we_i;
            mem_be_o = ls_be_i;
        end
    end

    // Owner of the transaction whose response arrives next cycle.
    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt_o) begin
            owner_d = OWN_IF;
        end else if (ls_gnt_o) begin
            owner_d = OWN_LS;
        end
    end

    // Reset clears the owner, so an in-flight response is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign if_rvalid_o = (owner_q == OWN_IF);
    assign ls_rvalid_o = (owner_q == OWN_LS);

    // Read data is broadcast; each port qualifies it with its own rvalid.
    assign if_rdata_o  = mem_rdata_i;
    assign ls_rdata_o  = mem_rdata_i;

endmodule
